// File: rtl/text_console_ctrl.sv
// Write-side controller for text_buffer: takes PUTC/NEWLINE/CLEAR/SETCUR commands,
// tracks the text cursor on a COLS x ROWS grid and drives the buffer write port.
module text_console_ctrl #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter logic [3:0]  CLEAR_CHAR = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [11:0] req_data,
    output logic [3:0]  new_char,
    output logic [11:0] waddr,
    output logic        we,
    output logic [11:0] cursor,
    output logic        busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [11:0] CELLS_W   = 12'(CELLS);
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [6:0]  COLS_C    = 7'(COLS);
    localparam logic [4:0]  ROWS_C    = 5'(ROWS);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    localparam logic [1:0] CMD_PUTC    = 2'b00;
    localparam logic [1:0] CMD_NEWLINE = 2'b01;
    localparam logic [1:0] CMD_CLEAR   = 2'b10;
    localparam logic [1:0] CMD_SETCUR  = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]  state_reg;
    logic        ready_reg;
    logic        busy_reg;
    logic        we_reg;
    logic [11:0] waddr_reg;
    logic [3:0]  new_char_reg;
    logic [11:0] cursor_reg;
    logic [11:0] row_base_reg;   // row_reg * COLS, kept alongside row_reg
    logic [6:0]  col_reg;
    logic [4:0]  row_reg;
    logic [11:0] clr_cnt_reg;    // next address the clear sequencer will write

    logic        accept;
    logic [6:0]  set_col;
    logic [4:0]  set_row;
    logic        set_ok;
    logic [11:0] set_base;

    assign accept   = req_valid && ready_reg;
    assign set_col  = req_data[6:0];
    assign set_row  = req_data[11:7];
    assign set_ok   = (set_col < COLS_C) && (set_row < ROWS_C);
    assign set_base = {7'd0, set_row} * COLS_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            new_char_reg <= '0;
            cursor_reg   <= '0;
            row_base_reg <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            clr_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    we_reg    <= 1'b0;
                    ready_reg <= 1'b1;
                    if (accept) begin
                        case (req_cmd)
                            CMD_PUTC: begin
                                we_reg       <= 1'b1;
                                waddr_reg    <= cursor_reg;
                                new_char_reg <= req_data[3:0];
                                if (cursor_reg == LAST_CELL) begin
                                    cursor_reg   <= '0;
                                    row_base_reg <= '0;
                                    col_reg      <= '0;
                                    row_reg      <= '0;
                                end else if (col_reg == LAST_COL) begin
                                    cursor_reg   <= cursor_reg + 12'd1;
                                    row_base_reg <= row_base_reg + COLS_W;
                                    col_reg      <= '0;
                                    row_reg      <= row_reg + 5'd1;
                                end else begin
                                    cursor_reg <= cursor_reg + 12'd1;
                                    col_reg    <= col_reg + 7'd1;
                                end
                            end
                            CMD_NEWLINE: begin
                                col_reg <= '0;
                                if (row_reg == LAST_ROW) begin
                                    row_reg      <= '0;
                                    row_base_reg <= '0;
                                    cursor_reg   <= '0;
                                end else begin
                                    row_reg      <= row_reg + 5'd1;
                                    row_base_reg <= row_base_reg + COLS_W;
                                    cursor_reg   <= row_base_reg + COLS_W;
                                end
                            end
                            CMD_CLEAR: begin
                                state_reg    <= ST_CLEAR;
                                ready_reg    <= 1'b0;
                                busy_reg     <= 1'b1;
                                we_reg       <= 1'b1;
                                waddr_reg    <= '0;
                                new_char_reg <= CLEAR_CHAR;
                                clr_cnt_reg  <= 12'd1;
                            end
                            CMD_SETCUR: begin
                                // Out-of-range positions are consumed without effect.
                                if (set_ok) begin
                                    row_reg      <= set_row;
                                    col_reg      <= set_col;
                                    row_base_reg <= set_base;
                                    cursor_reg   <= set_base + {5'd0, set_col};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_reg == CELLS_W) begin
                        state_reg    <= ST_IDLE;
                        ready_reg    <= 1'b1;
                        busy_reg     <= 1'b0;
                        we_reg       <= 1'b0;
                        cursor_reg   <= '0;
                        row_base_reg <= '0;
                        col_reg      <= '0;
                        row_reg      <= '0;
                    end else begin
                        we_reg      <= 1'b1;
                        waddr_reg   <= clr_cnt_reg;
                        clr_cnt_reg <= clr_cnt_reg + 12'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = ready_reg;
    assign busy      = busy_reg;
    assign we        = we_reg;
    assign waddr     = waddr_reg;
    assign new_char  = new_char_reg;
    assign cursor    = cursor_reg;

endmodule
